// File: rtl/recon_avm_pkg.sv
// Shared definitions for the Avalon-MM initiator: FSM states and response codes.
package recon_avm_pkg;

  // Transfer sequencing states; one transfer is in flight at a time.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Response status reported on rsp_error.
  typedef enum logic {
    RSP_OK      = 1'b0,
    RSP_TIMEOUT = 1'b1
  } rsp_err_t;

  localparam int unsigned TIMER_WIDTH = 16;

endpackage

// File: rtl/recon_avm_timeout.sv
// Stall timer: counts cycles while a transfer is pending and flags expiry.
module recon_avm_timeout
  import recon_avm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Expiry fires in the cycle whose increment would bring the count to the
  // limit, so the strobe is held for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TIMER_WIDTH-1:0] LP_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMER_WIDTH-1:0] r_count;

  // Cycle counter, restarted when a new transfer is launched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && !i_clear && (r_count == LP_LAST);

endmodule

// File: rtl/recon_avm_initiator.sv
// Single-outstanding Avalon-MM initiator bridging a cmd/rsp handshake interface.
module recon_avm_initiator
  import recon_avm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_byteenable,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  output logic [3:0]            avm_byteenable,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_nextState;

  logic [ADDR_WIDTH-1:0] r_avmAddress;
  logic                  r_avmRead;
  logic                  r_avmWrite;
  logic [31:0]           r_avmWritedata;
  logic [3:0]            r_avmByteenable;
  logic                  r_rspWrite;
  logic [31:0]           r_rspRdata;
  rsp_err_t              r_rspError;

  logic [ADDR_WIDTH-1:0] w_avmAddress;
  logic                  w_avmRead;
  logic                  w_avmWrite;
  logic [31:0]           w_avmWritedata;
  logic [3:0]            w_avmByteenable;
  logic                  w_rspWrite;
  logic [31:0]           w_rspRdata;
  rsp_err_t              w_rspError;

  logic                  w_toClear;
  logic                  w_toEnable;
  logic                  w_expired;

  // Timer restarts on command acceptance and runs while the slave owes us something.
  assign w_toClear  = (r_state == ST_IDLE) && cmd_valid;
  assign w_toEnable = (r_state == ST_REQ) || (r_state == ST_WAIT_RD);

  recon_avm_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_toClear),
    .i_enable (w_toEnable),
    .o_expired(w_expired)
  );

  // Next-state and next-register decode; a completed handshake wins over a
  // timeout that lands in the same cycle.
  always_comb begin
    w_nextState     = r_state;
    w_avmAddress    = r_avmAddress;
    w_avmRead       = r_avmRead;
    w_avmWrite      = r_avmWrite;
    w_avmWritedata  = r_avmWritedata;
    w_avmByteenable = r_avmByteenable;
    w_rspWrite      = r_rspWrite;
    w_rspRdata      = r_rspRdata;
    w_rspError      = r_rspError;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_nextState     = ST_REQ;
          w_avmAddress    = cmd_addr;
          w_avmWritedata  = cmd_wdata;
          w_avmByteenable = cmd_byteenable;
          w_avmRead       = !cmd_write;
          w_avmWrite      = cmd_write;
        end
      end
      ST_REQ: begin
        if (!avm_waitrequest) begin
          w_avmRead  = 1'b0;
          w_avmWrite = 1'b0;
          if (r_avmWrite) begin
            w_nextState = ST_RESP;
            w_rspWrite  = 1'b1;
            w_rspRdata  = '0;
            w_rspError  = RSP_OK;
          end else if (avm_readdatavalid) begin
            w_nextState = ST_RESP;
            w_rspWrite  = 1'b0;
            w_rspRdata  = avm_readdata;
            w_rspError  = RSP_OK;
          end else begin
            w_nextState = ST_WAIT_RD;
          end
        end else if (w_expired) begin
          w_avmRead   = 1'b0;
          w_avmWrite  = 1'b0;
          w_nextState = ST_RESP;
          w_rspWrite  = r_avmWrite;
          w_rspRdata  = '0;
          w_rspError  = RSP_TIMEOUT;
        end
      end
      ST_WAIT_RD: begin
        if (avm_readdatavalid) begin
          w_nextState = ST_RESP;
          w_rspWrite  = 1'b0;
          w_rspRdata  = avm_readdata;
          w_rspError  = RSP_OK;
        end else if (w_expired) begin
          w_nextState = ST_RESP;
          w_rspWrite  = 1'b0;
          w_rspRdata  = '0;
          w_rspError  = RSP_TIMEOUT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Avalon request and response holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_avmAddress    <= '0;
      r_avmRead       <= 1'b0;
      r_avmWrite      <= 1'b0;
      r_avmWritedata  <= '0;
      r_avmByteenable <= '0;
      r_rspWrite      <= 1'b0;
      r_rspRdata      <= '0;
      r_rspError      <= RSP_OK;
    end else begin
      r_avmAddress    <= w_avmAddress;
      r_avmRead       <= w_avmRead;
      r_avmWrite      <= w_avmWrite;
      r_avmWritedata  <= w_avmWritedata;
      r_avmByteenable <= w_avmByteenable;
      r_rspWrite      <= w_rspWrite;
      r_rspRdata      <= w_rspRdata;
      r_rspError      <= w_rspError;
    end
  end

  // cmd_ready also looks at reset_n so it reads 0 while reset is held.
  assign cmd_ready      = reset_n && (r_state == ST_IDLE);
  assign busy           = (r_state != ST_IDLE);
  assign rsp_valid      = (r_state == ST_RESP);
  assign rsp_write      = r_rspWrite;
  assign rsp_rdata      = r_rspRdata;
  assign rsp_error      = r_rspError;
  assign avm_address    = r_avmAddress;
  assign avm_read       = r_avmRead;
  assign avm_write      = r_avmWrite;
  assign avm_writedata  = r_avmWritedata;
  assign avm_byteenable = r_avmByteenable;

endmodule

// File: tb/tb_recon_avm_initiator.sv
// Directed self-checking bench for recon_avm_initiator (timeout set to 8 cycles).
module tb_recon_avm_initiator;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_byteenable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic        busy;

  int compared;
  int mismatched;
  int strobeCount;

  recon_avm_initiator #(
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_write        (cmd_write),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .cmd_byteenable   (cmd_byteenable),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_write        (rsp_write),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_readdata     (avm_readdata),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [31:0] addr);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
  endtask

  // Linear sequence of directed transfers.
  initial begin
    compared          = 0;
    mismatched        = 0;
    reset_n           = 1'b0;
    cmd_valid         = 1'b0;
    cmd_write         = 1'b0;
    cmd_addr          = 32'h0;
    cmd_wdata         = 32'hA5A5_5A5A;
    cmd_byteenable    = 4'hF;
    rsp_ready         = 1'b0;
    avm_readdata      = 32'h0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;

    #2;
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_avm_read", 32'(avm_read), 32'd0);
    checkOutput("rst_avm_write", 32'(avm_write), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_avm_address", avm_address, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 32'h0000_0004);
    step();
    cmd_valid = 1'b0;
    checkOutput("wr_avm_write", 32'(avm_write), 32'd1);
    checkOutput("wr_avm_address", avm_address, 32'h0000_0004);
    checkOutput("wr_avm_writedata", avm_writedata, 32'hA5A5_5A5A);
    checkOutput("wr_avm_byteenable", 32'(avm_byteenable), 32'hF);
    checkOutput("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("wr_rsp_valid_early", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("wr_avm_write_drop", 32'(avm_write), 32'd0);
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("wr_rsp_write", 32'(rsp_write), 32'd1);
    checkOutput("wr_rsp_error", 32'(rsp_error), 32'd0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("wr_done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] read with 3 wait states");
    avm_waitrequest = 1'b1;
    applyStimulus(1'b0, 32'h0000_0010);
    step();
    cmd_valid   = 1'b0;
    strobeCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (avm_read) strobeCount++;
      if (i == 3) avm_waitrequest = 1'b0;
      step();
    end
    checkOutput("rd_strobe_cycles", 32'(strobeCount), 32'd4);
    checkOutput("rd_avm_read_drop", 32'(avm_read), 32'd0);
    checkOutput("rd_wait_busy", 32'(busy), 32'd1);
    checkOutput("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h1234_5678;
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    checkOutput("rd_rsp_write", 32'(rsp_write), 32'd0);
    checkOutput("rd_rsp_error", 32'(rsp_error), 32'd0);

    $display("[TB] response backpressure");
    applyStimulus(1'b1, 32'h0000_0080);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
      checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("bp_avm_strobes", {30'd0, avm_read, avm_write}, 32'd0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checkOutput("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_done_busy", 32'(busy), 32'd0);

    $display("[TB] read timeout");
    avm_waitrequest = 1'b1;
    applyStimulus(1'b0, 32'h0000_0020);
    step();
    cmd_valid   = 1'b0;
    strobeCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (avm_read) strobeCount++;
      step();
    end
    checkOutput("to_strobe_cycles", 32'(strobeCount), 32'd8);
    checkOutput("to_avm_read_drop", 32'(avm_read), 32'd0);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("to_rsp_error", 32'(rsp_error), 32'd1);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'd0);
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hDEAD_BEEF;
    step();
    checkOutput("to_late_rdata", rsp_rdata, 32'd0);
    checkOutput("to_late_error", 32'(rsp_error), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    checkOutput("to_late_idle_busy", 32'(busy), 32'd0);
    checkOutput("to_late_idle_rsp_valid", 32'(rsp_valid), 32'd0);

    $display("[TB] same-cycle read data");
    applyStimulus(1'b0, 32'h0000_0030);
    step();
    cmd_valid = 1'b0;
    checkOutput("fast_avm_read", 32'(avm_read), 32'd1);
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'hCAFE_0001;
    step();
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'h0;
    checkOutput("fast_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("fast_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    checkOutput("fast_rsp_error", 32'(rsp_error), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("[TB] reset during WAIT_RD");
    applyStimulus(1'b0, 32'h0000_0040);
    step();
    cmd_valid = 1'b0;
    step();
    checkOutput("mid_wait_busy", 32'(busy), 32'd1);
    checkOutput("mid_wait_avm_read", 32'(avm_read), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("mid_rst_avm_address", avm_address, 32'd0);
    checkOutput("mid_rst_avm_writedata", avm_writedata, 32'd0);
    checkOutput("mid_rst_avm_byteenable", 32'(avm_byteenable), 32'd0);
    checkOutput("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    reset_n           = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    avm_readdatavalid = 1'b0;
    checkOutput("post_rst_rsp_rdata", rsp_rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/recon_avm_initiator.md
RECON_AVM_INITIATOR -- requirements
Module: recon_avm_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Avalon byte-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles a transfer may stall before it is aborted (legal range 1..65535).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, ports named clk and reset_n.
REQ-004 Ports, in the form name direction width meaning:
 clk  in  1  rising-edge clock
 reset_n  in  1  async active-low reset
 cmd_valid  in  1  command present
 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
 cmd_write  in  1  1=write, 0=read
 cmd_addr  in  ADDR_WIDTH  byte address
 cmd_wdata  in  32  write data
 cmd_byteenable  in  4  byte lanes
 rsp_valid  out  1  response present
 rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
 rsp_write  out  1  response belongs to a write
 rsp_rdata  out  32  read data (0 for writes/errors)
 rsp_error  out  1  transfer timed out
 avm_address  out  ADDR_WIDTH  Avalon address
 avm_read  out  1  Avalon read strobe
 avm_write  out  1  Avalon write strobe
 avm_writedata  out  32  Avalon write data
 avm_byteenable  out  4  Avalon byte enables
 avm_readdata  in  32  Avalon read data
 avm_waitrequest  in  1  slave stall
 avm_readdatavalid  in  1  pipelined read data valid
 busy  out  1  state != IDLE

Function
REQ-005 SHALL implement states IDLE, REQ, WAIT_RD, RESP; one transfer outstanding at a time.
REQ-006 IDLE: cmd_ready=1; on cmd_valid, SHALL register cmd_write, cmd_addr, cmd_wdata and cmd_byteenable into avm_* and enter REQ the next cycle.
REQ-007 cmd_ready SHALL be 0 in all states other than IDLE.
REQ-008 REQ: avm_read or avm_write SHALL be held high, with address, data and byteenable stable, until a cycle with avm_waitrequest=0.
REQ-009 REQ, write accepted: SHALL drop avm_write next cycle, enter RESP with rsp_write=1, rsp_rdata=0, rsp_error=0.
REQ-010 REQ, read accepted: SHALL drop avm_read next cycle and enter WAIT_RD; if avm_readdatavalid is also 1 in the acceptance cycle, SHALL capture avm_readdata and go directly to RESP.
REQ-011 WAIT_RD: on avm_readdatavalid, SHALL capture avm_readdata into rsp_rdata and enter RESP with rsp_error=0.
REQ-012 avm_readdatavalid outside REQ/WAIT_RD, including a late response after timeout, SHALL be ignored.
REQ-013 Timeout counter (16-bit) SHALL clear on entry to REQ and increment each cycle in REQ or WAIT_RD; on reaching TIMEOUT_CYCLES, SHALL deassert avm_read/avm_write, enter RESP with rsp_error=1, rsp_rdata=0.
REQ-014 RESP: rsp_valid=1, rsp_* stable until rsp_ready; SHALL return to IDLE the cycle after rsp_valid&rsp_ready.
REQ-015 Command to avm strobe latency SHALL be 1 cycle; zero-wait write command-accept to rsp_valid SHALL be 2 cycles.
REQ-016 Back-to-back: a new command SHALL be accepted no earlier than the first IDLE cycle after the response handshake.

Reset
REQ-017 On reset_n=0, SHALL go to IDLE; cmd_ready=0 while reset_n=0, then 1 in IDLE; avm_read=avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_error=0, busy=0, counter=0.
REQ-018 Reset mid-transfer SHALL abort immediately with no response generated.

Structure
REQ-019 State encoding and the response-error code SHALL live in shared package recon_avm_pkg.
REQ-020 Timeout counter SHALL be sub-module recon_avm_timeout (clear, enable, expired output); the rest stays flat.

Verification
REQ-021 Write 0x0000_0004 data 0xA5A5_5A5A be 0xF, waitrequest=0 -> one avm_write cycle, rsp_valid 2 cycles after accept, rsp_write=1, rsp_error=0.
REQ-022 Read 0x10, waitrequest high 3 cycles, readdatavalid 2 cycles later with 0x1234_5678 -> avm_read high exactly 4 cycles, rsp_rdata=0x1234_5678.
REQ-023 TIMEOUT_CYCLES=8, waitrequest stuck high -> strobe drops after 8 cycles, rsp_error=1, rsp_rdata=0; late readdatavalid then ignored.
REQ-024 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0 throughout, no new avm strobe.
REQ-025 reset_n pulsed low during WAIT_RD -> all outputs at reset values asynchronously, no rsp_valid afterwards.
REQ-026 Same-cycle read accept with readdatavalid=1, data 0xCAFE_0001 -> WAIT_RD skipped, rsp_rdata=0xCAFE_0001.
